// File: rtl/horner_seq_ctrl.sv
// horner_seq_ctrl: timing sequencer for the multi-channel Horner polynomial datapath
module horner_seq_ctrl #(
    parameter int N_CH       = 32,
    parameter int GROUP      = 16,
    parameter int ORDER      = 10,
    parameter int ITER_DLY   = 16,
    parameter int PIPE_DLY   = 21,
    parameter int RESTART_EN = 1,
    localparam int CW = ORDER > 0 ? $clog2(ORDER + 1) : 1,
    localparam int SW = N_CH > 1 ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            GlobalReset,
    input  logic            srdyi,
    output logic [CW-1:0]   coeff_sel,
    output logic            sum_rst,
    output logic            sum_en,
    output logic [SW-1:0]   channel_select,
    output logic [N_CH-1:0] enableRegControl,
    output logic            busy,
    output logic            overrun,
    output logic            srdyo
);
    localparam int NPASS = N_CH / GROUP;
    localparam int PW    = NPASS > 1 ? $clog2(NPASS) : 1;
    localparam int LW    = ITER_DLY > 1 ? $clog2(ITER_DLY) : 1;
    localparam int TMAX  = PIPE_DLY > GROUP ? PIPE_DLY : GROUP;
    localparam int TW    = TMAX > 1 ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {IDLE, EVAL, WAIT, WB, DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   p_q, p_d;
    logic [CW-1:0]   k_q, k_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [TW-1:0]   t_q, t_d;
    logic            ovr_q, ovr_d;
    logic [CW-1:0]   cs_hold_q, cs_hold_d;
    logic [SW-1:0]   ch_hold_q, ch_hold_d;
    logic [CW-1:0]   coeff_now;
    logic [SW-1:0]   chan_now;
    logic [SW-1:0]   wr_idx;
    logic            lane_last;

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_q   <= IDLE;
            p_q       <= '0;
            k_q       <= '0;
            lane_q    <= '0;
            t_q       <= '0;
            ovr_q     <= 1'b0;
            cs_hold_q <= '0;
            ch_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            k_q       <= k_d;
            lane_q    <= lane_d;
            t_q       <= t_d;
            ovr_q     <= ovr_d;
            cs_hold_q <= cs_hold_d;
            ch_hold_q <= ch_hold_d;
        end
    end

    // Step k and lane are kept as separate counters so no divider is needed.
    always_comb begin
        coeff_now = CW'(ORDER) - k_q;
        chan_now  = SW'(int'(p_q) * GROUP + ((int'(lane_q) < GROUP) ? int'(lane_q) : GROUP - 1));
        wr_idx    = SW'(int'(p_q) * GROUP + int'(t_q));
        lane_last = lane_q == LW'(ITER_DLY - 1);
        state_d   = state_q;
        p_d       = p_q;
        k_d       = k_q;
        lane_d    = lane_q;
        t_d       = t_q;
        ovr_d     = 1'b0;
        case (state_q)
            EVAL: begin
                lane_d = lane_last ? '0 : lane_q + LW'(1);
                if (lane_last && k_q == CW'(ORDER)) begin
                    state_d = PIPE_DLY == 0 ? WB : WAIT;
                    t_d     = '0;
                end else if (lane_last) begin
                    k_d = k_q + CW'(1);
                end
            end
            WAIT: begin
                state_d = t_q == TW'(PIPE_DLY - 1) ? WB : WAIT;
                t_d     = t_q == TW'(PIPE_DLY - 1) ? '0 : t_q + TW'(1);
            end
            WB: begin
                t_d = t_q + TW'(1);
                if (t_q == TW'(GROUP - 1)) begin
                    state_d = p_q == PW'(NPASS - 1) ? DONE : EVAL;
                    p_d     = p_q == PW'(NPASS - 1) ? p_q : p_q + PW'(1);
                    k_d     = '0;
                    lane_d  = '0;
                    t_d     = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
        endcase
        // A start while busy either restarts from pass 0 or is dropped and flagged.
        if (srdyi && (state_q == IDLE || RESTART_EN != 0)) begin
            state_d = EVAL;
            p_d     = '0;
            k_d     = '0;
            lane_d  = '0;
            t_d     = '0;
        end else if (srdyi) begin
            ovr_d = 1'b1;
        end
        cs_hold_d = state_q == EVAL ? coeff_now : cs_hold_q;
        ch_hold_d = state_q == EVAL ? chan_now : ch_hold_q;
    end

    assign coeff_sel        = state_q == EVAL ? coeff_now : cs_hold_q;
    assign channel_select   = state_q == EVAL ? chan_now : ch_hold_q;
    assign sum_rst          = state_q == EVAL && k_q == '0 && lane_q == '0;
    assign sum_en           = state_q == EVAL && k_q != '0;
    assign enableRegControl = state_q == WB ? N_CH'(1) << wr_idx : '0;
    assign busy             = state_q != IDLE;
    assign overrun          = ovr_q;
    assign srdyo            = state_q == DONE;
endmodule

// File: tb/tb_horner_seq_ctrl.sv
// tb_horner_seq_ctrl: three configurations driven together and checked against an arithmetic run-timeline model
module tb_horner_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic srdyi = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  cs0, cs1;
    logic [4:0]  ch0, ch1;
    logic [31:0] en0, en1;
    logic        sr0, se0, bz0, ov0, so0, sr1, se1, bz1, ov1, so1;
    logic [1:0]  cs2;
    logic [2:0]  ch2;
    logic [7:0]  en2;
    logic        sr2, se2, bz2, ov2, so2;

    horner_seq_ctrl #(.RESTART_EN(1)) d0 (.clk(clk), .GlobalReset(rst), .srdyi(srdyi),
        .coeff_sel(cs0), .sum_rst(sr0), .sum_en(se0), .channel_select(ch0),
        .enableRegControl(en0), .busy(bz0), .overrun(ov0), .srdyo(so0));
    horner_seq_ctrl #(.RESTART_EN(0)) d1 (.clk(clk), .GlobalReset(rst), .srdyi(srdyi),
        .coeff_sel(cs1), .sum_rst(sr1), .sum_en(se1), .channel_select(ch1),
        .enableRegControl(en1), .busy(bz1), .overrun(ov1), .srdyo(so1));
    horner_seq_ctrl #(.N_CH(8), .GROUP(4), .ORDER(3), .ITER_DLY(6), .PIPE_DLY(0), .RESTART_EN(1)) d2 (
        .clk(clk), .GlobalReset(rst), .srdyi(srdyi),
        .coeff_sel(cs2), .sum_rst(sr2), .sum_en(se2), .channel_select(ch2),
        .enableRegControl(en2), .busy(bz2), .overrun(ov2), .srdyo(so2));

    int p_nch[3] = '{32, 32, 8};
    int p_grp[3] = '{16, 16, 4};
    int p_ord[3] = '{10, 10, 3};
    int p_itr[3] = '{16, 16, 6};
    int p_pip[3] = '{21, 21, 0};
    int p_rse[3] = '{1, 0, 1};

    typedef struct {
        int          cs;
        int          ch;
        bit          srst;
        bit          sen;
        logic [31:0] en;
        bit          busy;
        bit          so;
    } exp_t;

    int  cyc = 0;
    bit  checking = 1'b0;
    bit  active[3];
    int  start[3];
    int  hold_cs[3];
    int  hold_ch[3];
    bit  ovr_exp[3];
    int  vectors = 0;
    int  miscompares = 0;
    int  q_so0[$], q_so1[$], q_so2[$], q_ov1[$], q_b0[$], q_b31[$], q_sr0[$];

    // Expected outputs of instance i, r cycles after the first EVAL cycle of its run.
    function automatic exp_t model(int i, int r, bit act);
        exp_t e;
        int el, pl, tot, p, w, k, lane;
        e = '{cs: hold_cs[i], ch: hold_ch[i], srst: 0, sen: 0, en: '0, busy: 0, so: 0};
        el  = (p_ord[i] + 1) * p_itr[i];
        pl  = el + p_pip[i] + p_grp[i];
        tot = (p_nch[i] / p_grp[i]) * pl;
        if (!act || r < 0 || r > tot) return e;
        e.busy = 1;
        if (r == tot) begin
            e.so = 1;
            return e;
        end
        p = r / pl;
        w = r % pl;
        if (w < el) begin
            k      = w / p_itr[i];
            lane   = w % p_itr[i];
            e.cs   = p_ord[i] - k;
            e.ch   = p * p_grp[i] + (lane < p_grp[i] ? lane : p_grp[i] - 1);
            e.srst = w == 0;
            e.sen  = k >= 1;
        end else if (w >= el + p_pip[i]) begin
            e.en = 32'd1 << (p * p_grp[i] + w - el - p_pip[i]);
        end
        return e;
    endfunction

    task automatic chk(string nm, int i, longint act, longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s inst%0d cycle %0d: got %0d (0x%0h) expected %0d (0x%0h)", nm, i, cyc, act, act, req, req);
        end
    endtask

    task automatic cmp_inst(int i, int cs, int ch, bit srst, bit sen, logic [31:0] en, bit bz, bit ov, bit so);
        exp_t e;
        e = model(i, cyc - start[i], active[i]);
        chk("coeff_sel", i, cs, e.cs);
        chk("channel_select", i, ch, e.ch);
        chk("sum_rst", i, srst, e.srst);
        chk("sum_en", i, sen, e.sen);
        chk("enableRegControl", i, en, e.en);
        chk("busy", i, bz, e.busy);
        chk("overrun", i, ov, ovr_exp[i]);
        chk("srdyo", i, so, e.so);
    endtask

    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e = model(i, cyc - start[i], active[i]);
            hold_cs[i] = e.cs;
            hold_ch[i] = e.ch;
            ovr_exp[i] = 0;
            if (rst) begin
                active[i]  = 0;
                hold_cs[i] = 0;
                hold_ch[i] = 0;
            end else if (srdyi && (!e.busy || p_rse[i] != 0)) begin
                active[i] = 1;
                start[i]  = cyc + 1;
            end else if (srdyi) begin
                ovr_exp[i] = 1;
            end
        end
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (checking) begin
            cmp_inst(0, int'(cs0), int'(ch0), sr0, se0, en0, bz0, ov0, so0);
            cmp_inst(1, int'(cs1), int'(ch1), sr1, se1, en1, bz1, ov1, so1);
            cmp_inst(2, int'(cs2), int'(ch2), sr2, se2, {24'd0, en2}, bz2, ov2, so2);
            if (so0) q_so0.push_back(cyc);
            if (so1) q_so1.push_back(cyc);
            if (so2) q_so2.push_back(cyc);
            if (ov1) q_ov1.push_back(cyc);
            if (en0[0]) q_b0.push_back(cyc);
            if (en0[31]) q_b31.push_back(cyc);
            if (sr0) q_sr0.push_back(cyc);
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(output int e0);
        srdyi = 1'b1;
        e0 = cyc;
        tick(1);
        srdyi = 1'b0;
    endtask

    task automatic clear_logs();
        q_so0.delete(); q_so1.delete(); q_so2.delete();
        q_ov1.delete(); q_b0.delete(); q_b31.delete(); q_sr0.delete();
    endtask

    function automatic int first(int q[$]);
        return q.size() > 0 ? q[0] : -1;
    endfunction

    function automatic int second(int q[$]);
        return q.size() > 1 ? q[1] : -1;
    endfunction

    initial begin
        int e0, e1;
        for (int i = 0; i < 3; i++) begin
            active[i] = 0; start[i] = 0; hold_cs[i] = 0; hold_ch[i] = 0; ovr_exp[i] = 0;
        end
        tick(3);
        checking = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);

        clear_logs();
        pulse(e0);
        tick(440);
        chk("srdyo_count", 0, q_so0.size(), 1);
        chk("srdyo_at", 0, first(q_so0), e0 + 427);
        chk("srdyo_at", 1, first(q_so1), e0 + 427);
        chk("srdyo_at", 2, first(q_so2), e0 + 57);
        chk("sum_rst_first", 0, first(q_sr0), e0 + 1);
        chk("sum_rst_second", 0, second(q_sr0), e0 + 214);
        chk("bit0_at", 0, first(q_b0), e0 + 198);
        chk("bit0_count", 0, q_b0.size(), 1);
        chk("bit31_at", 0, first(q_b31), e0 + 426);

        clear_logs();
        pulse(e0);
        tick(99);
        pulse(e1);
        tick(540);
        chk("restart_srdyo_count", 0, q_so0.size(), 1);
        chk("restart_srdyo_at", 0, first(q_so0), e0 + 527);
        chk("restart_bit0_last", 0, q_b0.size() > 0 ? q_b0[q_b0.size() - 1] : -1, e0 + 298);
        chk("overrun_at", 1, first(q_ov1), e0 + 101);
        chk("overrun_count", 1, q_ov1.size(), 1);
        chk("norestart_srdyo_at", 1, first(q_so1), e0 + 427);

        clear_logs();
        pulse(e0);
        tick(299);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(200);
        chk("reset_no_srdyo", 0, q_so0.size(), 0);
        chk("reset_no_srdyo", 1, q_so1.size(), 0);
        pulse(e1);
        tick(440);
        chk("after_reset_srdyo_at", 0, first(q_so0), e1 + 427);

        repeat (6000) begin
            srdyi = $urandom_range(0, 299) == 0;
            rst   = $urandom_range(0, 1999) == 0;
            tick(1);
        end
        srdyi = 1'b0;
        rst   = 1'b0;
        tick(500);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
